// File: rtl/sipo_pkg.sv
// Shared definitions for the sipo_rx serial receiver: FSM state encoding and
// helpers that size the bit counter and frame length from WIDTH.
// Optional feature macro: SIPO_PARITY_CHECK_EN (adds one even-parity bit per frame).
package sipo_pkg;

  typedef logic [0:0] state_t;

  localparam state_t S_IDLE  = 1'b0;
  localparam state_t S_SHIFT = 1'b1;

  // Counter must hold 0..WIDTH so the parity bit slot fits when enabled.
  function automatic int cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

  // Number of serial bits that make up one frame.
  function automatic int frame_len(input int width);
`ifdef SIPO_PARITY_CHECK_EN
    return width + 1;
`else
    return width;
`endif
  endfunction

endpackage

// File: rtl/sipo_out_buf.sv
// One-entry valid/ready output register with a sticky overrun flag.
// Ports: load/load_data (new word), data_out/data_valid/data_ready (consumer side),
//        overrun (word dropped while full), parity_err/load_perr with SIPO_PARITY_CHECK_EN.
module sipo_out_buf
  import sipo_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
`ifdef SIPO_PARITY_CHECK_EN
  input  logic             load_perr,
  output logic             parity_err,
`endif
  input  logic             data_ready,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  output logic             overrun
);

  // A new word may enter when the buffer is empty or is being drained this
  // same edge; the latter gives back-to-back delivery with no bubble.
  logic can_load;
  assign can_load = !data_valid || data_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out   <= '0;
      data_valid <= 1'b0;
      overrun    <= 1'b0;
`ifdef SIPO_PARITY_CHECK_EN
      parity_err <= 1'b0;
`endif
    end else begin
      if (load && can_load) begin
        data_out   <= load_data;
        data_valid <= 1'b1;
`ifdef SIPO_PARITY_CHECK_EN
        parity_err <= load_perr;
`endif
      end else if (data_valid && data_ready) begin
        data_valid <= 1'b0;
      end
      // Held word is left untouched; only the flag records the loss.
      if (load && !can_load) begin
        overrun <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/sipo_rx.sv
// Serial-in/parallel-out receiver: frames bit_valid-qualified bits into WIDTH-bit words.
// Ports: serial_in/bit_valid/frame_start (serial side), data_out/data_valid/data_ready,
//        overrun, busy; parity_err when SIPO_PARITY_CHECK_EN is defined.
module sipo_rx
  import sipo_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             serial_in,
  input  logic             bit_valid,
  input  logic             frame_start,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  input  logic             data_ready,
  output logic             overrun,
`ifdef SIPO_PARITY_CHECK_EN
  output logic             parity_err,
`endif
  output logic             busy
);

  localparam int CNT_W = cnt_w(WIDTH);
  localparam int FLEN  = frame_len(WIDTH);

  state_t           state;
  logic [CNT_W-1:0] bit_cnt;
  logic [CNT_W-1:0] cnt_eff;
  logic [WIDTH-1:0] shift_reg;
  logic [WIDTH-1:0] shift_base;
  logic [WIDTH-1:0] shift_nxt;
  logic [WIDTH-1:0] word;
  logic             last;
`ifdef SIPO_PARITY_CHECK_EN
  logic             perr;
`endif

  always_comb begin
    // frame_start discards the partial frame before this cycle's bit is taken.
    cnt_eff    = frame_start ? '0 : bit_cnt;
    shift_base = frame_start ? '0 : shift_reg;
    shift_nxt  = shift_base;
    // Only data-bit slots shift; the parity slot (if any) never enters shift_reg.
    if (bit_valid && (cnt_eff < CNT_W'(WIDTH))) begin
      if (MSB_FIRST) begin
        shift_nxt = {shift_base[WIDTH-2:0], serial_in};
      end else begin
        shift_nxt = {serial_in, shift_base[WIDTH-1:1]};
      end
    end
    last = bit_valid && (cnt_eff == CNT_W'(FLEN - 1));
`ifdef SIPO_PARITY_CHECK_EN
    // Last bit is the parity bit: data is already complete in shift_base.
    word = shift_base;
    perr = (^shift_base) ^ serial_in;
`else
    // Last bit is a data bit: bypass it straight into the word.
    word = shift_nxt;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      bit_cnt   <= '0;
      shift_reg <= '0;
    end else if (last) begin
      state     <= S_IDLE;
      bit_cnt   <= '0;
      shift_reg <= '0;
    end else if (bit_valid) begin
      state     <= S_SHIFT;
      bit_cnt   <= cnt_eff + 1'b1;
      shift_reg <= shift_nxt;
    end else if (frame_start) begin
      state     <= S_IDLE;
      bit_cnt   <= '0;
      shift_reg <= '0;
    end
  end

  assign busy = (state == S_SHIFT);

  sipo_out_buf #(
    .WIDTH(WIDTH)
  ) u_out_buf (
    .clk       (clk),
    .rst       (reset),
    .load      (last),
    .load_data (word),
`ifdef SIPO_PARITY_CHECK_EN
    .load_perr (perr),
    .parity_err(parity_err),
`endif
    .data_ready(data_ready),
    .data_out  (data_out),
    .data_valid(data_valid),
    .overrun   (overrun)
  );

endmodule

// File: tb/tb_sipo_rx.sv
// Directed bench for sipo_rx: an MSB-first and an LSB-first instance share
// the same serial stimulus; expected words are queued as frames are sent and
// popped when the consumer handshake takes them.
module tb_sipo_rx;

  logic       clk = 1'b0;
  logic       reset;
  logic       serial_in;
  logic       bit_valid;
  logic       frame_start;
  logic       data_ready;
  logic [3:0] data_out;
  logic       data_valid;
  logic       overrun;
  logic       busy;
  logic [3:0] l_data_out;
  logic       l_data_valid;
  logic       l_overrun;
  logic       l_busy;
`ifdef SIPO_PARITY_CHECK_EN
  logic       parity_err;
  logic       l_parity_err;
`endif

  int n_vec = 0;
  int n_err = 0;

  logic [3:0] q_msb[$];
  logic [3:0] q_lsb[$];
  logic       q_perr[$];

  always #5 clk = ~clk;

  sipo_rx #(.WIDTH(4), .MSB_FIRST(1'b1)) dut (
    .clk        (clk),
    .reset      (reset),
    .serial_in  (serial_in),
    .bit_valid  (bit_valid),
    .frame_start(frame_start),
    .data_out   (data_out),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .overrun    (overrun),
`ifdef SIPO_PARITY_CHECK_EN
    .parity_err (parity_err),
`endif
    .busy       (busy)
  );

  sipo_rx #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_lsb (
    .clk        (clk),
    .reset      (reset),
    .serial_in  (serial_in),
    .bit_valid  (bit_valid),
    .frame_start(frame_start),
    .data_out   (l_data_out),
    .data_valid (l_data_valid),
    .data_ready (data_ready),
    .overrun    (l_overrun),
`ifdef SIPO_PARITY_CHECK_EN
    .parity_err (l_parity_err),
`endif
    .busy       (l_busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] rev4(input logic [3:0] w);
    logic [3:0] r;
    for (int i = 0; i < 4; i++) r[i] = w[3-i];
    return r;
  endfunction

  // Scoreboard pop happens for the handshake that the coming edge completes.
  task automatic tick();
    if (data_valid && data_ready) begin
      if (q_msb.size() == 0) check("sb_msb_unexpected", data_out, 32'hdead);
      else check("sb_msb_word", data_out, q_msb.pop_front());
`ifdef SIPO_PARITY_CHECK_EN
      if (q_perr.size() == 0) check("sb_perr_unexpected", parity_err, 32'hdead);
      else check("sb_perr", parity_err, q_perr.pop_front());
`endif
    end
    if (l_data_valid && data_ready) begin
      if (q_lsb.size() == 0) check("sb_lsb_unexpected", l_data_out, 32'hdead);
      else check("sb_lsb_word", l_data_out, q_lsb.pop_front());
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    serial_in = b;
    bit_valid = 1'b1;
    tick();
    bit_valid = 1'b0;
    serial_in = 1'b0;
  endtask

  // Bits go out w[3] first; the LSB-first instance therefore sees rev4(w).
  task automatic push_exp(input logic [3:0] w, input logic flip);
    q_msb.push_back(w);
    q_lsb.push_back(rev4(w));
    q_perr.push_back(flip);
  endtask

  task automatic send_tail(input logic [3:0] w, input logic flip);
`ifdef SIPO_PARITY_CHECK_EN
    send_bit((^w) ^ flip);
`endif
  endtask

  task automatic send_word(input logic [3:0] w, input bit push, input logic flip);
    if (push) push_exp(w, flip);
    for (int i = 3; i >= 0; i--) send_bit(w[i]);
    send_tail(w, flip);
  endtask

  initial begin
    reset = 1'b1; serial_in = 1'b0; bit_valid = 1'b0;
    frame_start = 1'b0; data_ready = 1'b1;
    @(negedge clk);
    check("rst_data_out", data_out, 4'h0);
    check("rst_data_valid", data_valid, 1'b0);
    check("rst_overrun", overrun, 1'b0);
    check("rst_busy", busy, 1'b0);
`ifdef SIPO_PARITY_CHECK_EN
    check("rst_parity_err", parity_err, 1'b0);
`endif
    reset = 1'b0;
    tick();

    // Reset mid-frame: partial bits lost, next frame is clean.
    send_bit(1'b1);
    send_bit(1'b1);
    check("mid_busy", busy, 1'b1);
    reset = 1'b1;
    #2;
    check("async_rst_busy", busy, 1'b0);
    reset = 1'b0;
    send_word(4'b0101, 1'b1, 1'b0);
    check("post_rst_word", data_out, 4'b0101);
    tick();

    // Consecutive bits, one-cycle valid pulse with ready high.
    send_word(4'b1001, 1'b1, 1'b0);
    check("w1001_valid", data_valid, 1'b1);
    check("w1001_data", data_out, 4'b1001);
    tick();
    check("w1001_valid_drop", data_valid, 1'b0);

    send_word(4'b1100, 1'b1, 1'b0);
    check("lsb_0011", l_data_out, 4'b0011);
    tick();

    // Gap of two idle cycles between bits 2 and 3.
    push_exp(4'b1100, 1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    tick();
    tick();
    check("gap_busy", busy, 1'b1);
    check("gap_no_valid", data_valid, 1'b0);
    send_bit(1'b0);
    send_bit(1'b0);
    send_tail(4'b1100, 1'b0);
    check("gap_word", data_out, 4'b1100);
    tick();

    // Drain and reload on the same edge: no bubble, no overrun.
    data_ready = 1'b0;
    send_word(4'b0111, 1'b1, 1'b0);
    push_exp(4'b1110, 1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b1);
`ifdef SIPO_PARITY_CHECK_EN
    send_bit(1'b0);
`endif
    data_ready = 1'b1;
    send_tail(4'b1110, 1'b0);
    send_bit(1'b0);
    check("b2b_valid", data_valid, 1'b1);
    check("b2b_data", data_out, 4'b1110);
    check("b2b_no_overrun", overrun, 1'b0);
    tick();

    // Buffer full at completion: second word dropped, overrun sticks.
    data_ready = 1'b0;
    send_word(4'b1001, 1'b1, 1'b0);
    tick();
    send_word(4'b0110, 1'b0, 1'b0);
    check("ovr_data_held", data_out, 4'b1001);
    check("ovr_valid", data_valid, 1'b1);
    check("ovr_flag", overrun, 1'b1);
    check("ovr_flag_lsb", l_overrun, 1'b1);
    check("ovr_busy_idle", busy, 1'b0);
    data_ready = 1'b1;
    tick();
    check("ovr_consumed", data_valid, 1'b0);
    check("ovr_sticky", overrun, 1'b1);

    // frame_start resync carrying bit 0 of the new frame.
    send_bit(1'b1);
    send_bit(1'b1);
    push_exp(4'b0011, 1'b0);
    frame_start = 1'b1;
    send_bit(1'b0);
    frame_start = 1'b0;
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    send_tail(4'b0011, 1'b0);
    check("resync_word", data_out, 4'b0011);
    check("resync_lsb", l_data_out, 4'b1100);
    tick();

`ifdef SIPO_PARITY_CHECK_EN
    send_word(4'b1001, 1'b1, 1'b0);
    check("par_ok", parity_err, 1'b0);
    tick();
    send_word(4'b1001, 1'b1, 1'b1);
    check("par_bad", parity_err, 1'b1);
    check("par_bad_data", data_out, 4'b1001);
    tick();
`endif

    tick();
    check("sb_drained_msb", q_msb.size(), 0);
    check("sb_drained_lsb", q_lsb.size(), 0);
    check("final_overrun", overrun, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
